// File: rtl/irrigation_pkg.sv
// Shared definitions for the irrigation panel switch matrix: scan FSM states,
// switch-vector indexing and the default positions of the named sensors.
package irrigation_pkg;

   localparam int MATRIX_COLUMNS = 3;
   localparam int MATRIX_ROWS    = 3;

   typedef enum logic {
      SETTLE = 1'b0,
      SAMPLE = 1'b1
   } scan_state_t;

   function automatic int switch_index(input int col, input int row, input int rows = MATRIX_ROWS);
      return col * rows + row;
   endfunction

   // Sensor wiring on the default 3x3 panel matrix
   localparam int SW_LOW_WATER     = switch_index(0, 0);
   localparam int SW_MID_WATER     = switch_index(0, 1);
   localparam int SW_HIGH_WATER    = switch_index(0, 2);
   localparam int SW_EARTH_HUMID   = switch_index(1, 0);
   localparam int SW_AIR_HUMID     = switch_index(1, 1);
   localparam int SW_LOW_TEMP      = switch_index(1, 2);
   localparam int SW_SELECTOR      = switch_index(2, 0);

endpackage

// File: rtl/switch_matrix_scanner_debouncer.sv
// One debounced contact: flips its state after DEBOUNCE_SCANS consecutive
// differing samples; any matching sample restarts the count.
module switch_debouncer #(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic clock,
   input  logic reset_n,
   input  logic sample_en,
   input  logic sample,
   output logic state,
   output logic toggled
);

   localparam int CW = $clog2(DEBOUNCE_SCANS) + 1;

   logic [CW-1:0] r_count;
   logic          r_state;
   logic [CW-1:0] w_count_inc;
   logic          w_flip;

   // Next count and flip decision for the current sample
   always_comb begin
      w_count_inc = r_count + CW'(1);
      if (sample_en && (sample != r_state) && (w_count_inc == CW'(DEBOUNCE_SCANS))) begin
         w_flip = 1'b1;
      end else begin
         w_flip = 1'b0;
      end
   end

   // Counter and debounced state update, only on this contact's sample cycle
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
         r_state <= 1'b0;
      end else if (sample_en) begin
         if (sample == r_state) begin
            r_count <= '0;
         end else if (w_flip) begin
            r_state <= ~r_state;
            r_count <= '0;
         end else begin
            r_count <= w_count_inc;
         end
      end
   end

   assign state   = r_state;
   assign toggled = w_flip;

endmodule

// File: rtl/switch_matrix_scanner.sv
// Column-scanned switch matrix reader: drives one column at a time, samples the
// synchronized rows after a settle period and debounces every contact.
module switch_matrix_scanner
   import irrigation_pkg::*;
#(
   parameter int COLUMNS        = 3,
   parameter int ROWS           = 3,
   parameter int SETTLE_TICKS   = 4,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    scan_tick,
   input  logic [ROWS-1:0]         scan_row,
   output logic [COLUMNS-1:0]      scan_col,
   output logic [ROWS*COLUMNS-1:0] switches,
   output logic                    switches_valid,
   output logic                    change_pulse
);

   localparam int CIW = $clog2(COLUMNS) + 1;
   localparam int SCW = $clog2(SETTLE_TICKS) + 1;
   localparam int FCW = $clog2(DEBOUNCE_SCANS) + 1;
   localparam int NSW = ROWS * COLUMNS;

   scan_state_t      r_state;
   logic [CIW-1:0]   r_col_idx;
   logic [SCW-1:0]   r_settle_cnt;
   logic [FCW-1:0]   r_frame_cnt;
   logic [COLUMNS-1:0] r_scan_col;
   logic [ROWS-1:0]  r_sync1;
   logic [ROWS-1:0]  r_sync2;
   logic             r_valid;
   logic             r_change_pulse;

   logic [NSW-1:0]   w_sample_en;
   logic [NSW-1:0]   w_toggled;
   logic [NSW-1:0]   w_switches;
   logic [SCW-1:0]   w_settle_inc;
   logic [FCW-1:0]   w_frame_inc;
   logic             w_last_col;

   assign w_settle_inc = r_settle_cnt + SCW'(1);
   assign w_frame_inc  = r_frame_cnt + FCW'(1);
   assign w_last_col   = (r_col_idx == CIW'(COLUMNS - 1));

   genvar c, r;
   generate
      for (c = 0; c < COLUMNS; c++) begin : g_col
         for (r = 0; r < ROWS; r++) begin : g_row
            localparam int IDX = switch_index(c, r, ROWS);
            assign w_sample_en[IDX] = (r_state == SAMPLE) && (r_col_idx == CIW'(c));
            switch_debouncer #(
               .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
            ) u_debouncer (
               .clock     (clock),
               .reset_n   (reset_n),
               .sample_en (w_sample_en[IDX]),
               .sample    (r_sync2[r]),
               .state     (w_switches[IDX]),
               .toggled   (w_toggled[IDX])
            );
         end
      end
   endgenerate

   // Two-flop synchronizer for the asynchronous row returns
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= scan_row;
         r_sync2 <= r_sync1;
      end
   end

   // Scan FSM: settle on a column for SETTLE_TICKS ticks, then one sample cycle
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= SETTLE;
         r_col_idx      <= '0;
         r_settle_cnt   <= '0;
         r_frame_cnt    <= '0;
         r_scan_col     <= COLUMNS'(1);
         r_valid        <= 1'b0;
         r_change_pulse <= 1'b0;
      end else begin
         case (r_state)
            SETTLE: begin
               r_change_pulse <= 1'b0;
               if (scan_tick) begin
                  r_settle_cnt <= w_settle_inc;
                  if (w_settle_inc == SCW'(SETTLE_TICKS)) begin
                     r_state <= SAMPLE;
                  end
               end
            end
            SAMPLE: begin
               r_change_pulse <= |w_toggled;
               r_settle_cnt   <= '0;
               r_state        <= SETTLE;
               if (w_last_col) begin
                  r_col_idx  <= '0;
                  r_scan_col <= COLUMNS'(1);
                  // Frame count saturates once the debounce history is full
                  if (r_frame_cnt != FCW'(DEBOUNCE_SCANS)) begin
                     r_frame_cnt <= w_frame_inc;
                  end
                  if (w_frame_inc >= FCW'(DEBOUNCE_SCANS)) begin
                     r_valid <= 1'b1;
                  end
               end else begin
                  r_col_idx  <= r_col_idx + CIW'(1);
                  r_scan_col <= r_scan_col << 1;
               end
            end
            default: begin
               r_state        <= SETTLE;
               r_change_pulse <= 1'b0;
            end
         endcase
      end
   end

   assign scan_col       = r_scan_col;
   assign switches       = w_switches;
   assign switches_valid = r_valid;
   assign change_pulse   = r_change_pulse;

endmodule
